alu_cmd_issuer: RTL and testbench

//  Initiator side of the ALU: accepts register-level commands over a valid/ready handshake, reads

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_cmd_issuer.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default datapath width and issuer FSM states.
package alu_pkg;

    localparam int unsigned DW = 32;

    localparam logic [4:0] A_NOP = 5'h00;
    localparam logic [4:0] A_ADD = 5'h01;
    localparam logic [4:0] A_SUB = 5'h02;
    localparam logic [4:0] A_AND = 5'h03;
    localparam logic [4:0] A_OR  = 5'h04;
    localparam logic [4:0] A_XOR = 5'h05;
    localparam logic [4:0] A_NOR = 5'h06;
    localparam logic [4:0] A_LDI = 5'h1F;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } issuer_state_e;

    // True for opcodes the ALU itself executes (NOP..NOR).
    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= A_NOR;
    endfunction

    // Neither an ALU opcode nor LDI.
    function automatic logic is_illegal_op(input logic [4:0] op);
        return !is_alu_op(op) && (op != A_LDI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: 2**AW x DW, two async read ports, one sync write port, r0 reads as zero.
module alu_regfile #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    localparam int unsigned NumRegs = 2 ** AW;

    logic [DW-1:0] mem_q [NumRegs];

    // Storage with asynchronous clear; writes to r0 are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational reads with r0 forced to zero.
    always_comb begin
        rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command issuer: accepts register-level commands, drives the combinational ALU, writes the
// result back to the register file and returns it over a result handshake.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DW = alu_pkg::DW,
    parameter int unsigned AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [4:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_rd_i,
    input  logic [AW-1:0] cmd_rs_i,
    input  logic [AW-1:0] cmd_rt_i,
    input  logic [DW-1:0] cmd_imm_i,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [4:0]    alu_op_o,
    input  logic [DW-1:0] alu_out_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] res_data_o,
    output logic [AW-1:0] res_rd_o,
    output logic          res_err_o
);

    issuer_state_e state_q, state_d;

    logic [4:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [4:0]    alu_op_q;
    logic [DW-1:0] res_data_q;
    logic [AW-1:0] res_rd_q;
    logic          res_valid_q;
    logic          res_err_q;

    logic [DW-1:0] rdata_a, rdata_b;
    logic [DW-1:0] result;
    logic          cmd_fire;
    logic          wb_en;

    assign cmd_fire = cmd_valid_i && cmd_ready_o;
    assign wb_en    = (state_q == StCapture) && !is_illegal_op(op_q);

    // Operands are read at acceptance; any earlier write-back has already landed.
    alu_regfile #(
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .raddr_a_i (cmd_rs_i),
        .rdata_a_o (rdata_a),
        .raddr_b_i (cmd_rt_i),
        .rdata_b_o (rdata_b),
        .we_i      (wb_en),
        .waddr_i   (rd_q),
        .wdata_i   (result)
    );

    // Result selection: LDI bypasses the ALU, illegal opcodes yield zero.
    always_comb begin
        result = alu_out_i;
        if (op_q == A_LDI) begin
            result = imm_q;
        end else if (is_illegal_op(op_q)) begin
            result = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cmd_fire) state_d = StIssue;
            StIssue:   state_d = StCapture;
            StCapture: state_d = StResp;
            StResp:    if (res_ready_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready_o = (state_q == StIdle);
    end

    // Command latch, ALU-facing registers and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q        <= A_NOP;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= A_NOP;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q     <= cmd_op_i;
                rd_q     <= cmd_rd_i;
                imm_q    <= cmd_imm_i;
                alu_a_q  <= rdata_a;
                alu_b_q  <= rdata_b;
                alu_op_q <= is_alu_op(cmd_op_i) ? cmd_op_i : A_NOP;
            end
            if (state_q == StCapture) begin
                res_data_q  <= result;
                res_rd_q    <= rd_q;
                res_valid_q <= 1'b1;
                res_err_q   <= is_illegal_op(op_q);
            end
            if ((state_q == StResp) && res_ready_i) begin
                res_valid_q <= 1'b0;
                res_err_q   <= 1'b0;
            end
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_rd_o    = res_rd_q;
    assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU and register-file model.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int unsigned TAW = 3;
    localparam int unsigned TDW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [4:0]     cmd_op;
    logic [TAW-1:0] cmd_rd, cmd_rs, cmd_rt;
    logic [TDW-1:0] cmd_imm;
    logic [TDW-1:0] alu_a, alu_b, alu_out;
    logic [4:0]     alu_op;
    logic           res_valid, res_ready, res_err;
    logic [TDW-1:0] res_data;
    logic [TAW-1:0] res_rd;

    int total = 0;
    int bad   = 0;

    logic [TDW-1:0] model_rf [8];
    logic [TDW-1:0] got;

    always #5 clk = ~clk;

    alu_cmd_issuer #(
        .DW (TDW),
        .AW (TAW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_rd_i    (cmd_rd),
        .cmd_rs_i    (cmd_rs),
        .cmd_rt_i    (cmd_rt),
        .cmd_imm_i   (cmd_imm),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_out_i   (alu_out),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_rd_o    (res_rd),
        .res_err_o   (res_err)
    );

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            5'h01:   return a + b;
            5'h02:   return a - b;
            5'h03:   return a & b;
            5'h04:   return a | b;
            5'h05:   return a ^ b;
            5'h06:   return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    // The combinational ALU the issuer drives.
    always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cmd();
        cmd_op  = 5'($urandom);
        cmd_rd  = 3'($urandom);
        cmd_rs  = 3'($urandom);
        cmd_rt  = 3'($urandom);
        cmd_imm = $urandom;
    endtask

    // Runs one command end to end; entered and left at 1 time unit after a rising edge.
    task automatic run_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [31:0] imm, input int hold,
                           input bit rst_in_resp, output logic [31:0] obs);
        logic [31:0] a, b, exp_res;
        logic [4:0]  exp_aop;
        logic        exp_err;
        int          waited;
        a       = model_rf[rs];
        b       = model_rf[rt];
        exp_err = (op > 5'h06) && (op != 5'h1F);
        exp_aop = (op <= 5'h06) ? op : 5'h00;
        if (op == 5'h1F)  exp_res = imm;
        else if (exp_err) exp_res = 32'h0;
        else              exp_res = alu_f(op, a, b);

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble_cmd();
        check("issue_alu_a", alu_a, a);
        check("issue_alu_b", alu_b, b);
        check("issue_alu_op", 32'(alu_op), 32'(exp_aop));
        check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
        check("issue_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("capture_res_valid", 32'(res_valid), 32'd0);
        waited = 0;
        while (!res_valid && waited < 3) begin
            @(posedge clk); #1;
            waited++;
        end
        check("res_valid_rise", 32'(res_valid), 32'd1);
        check("res_data", res_data, exp_res);
        check("res_rd", 32'(res_rd), 32'(rd));
        check("res_err", 32'(res_err), 32'(exp_err));
        obs = res_data;

        if (rst_in_resp) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            check("rst_res_data", res_data, 32'd0);
            check("rst_alu_a", alu_a, 32'd0);
            for (int i = 0; i < 8; i++) model_rf[i] = 32'h0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            scramble_cmd();
            @(posedge clk); #1;
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_data", res_data, exp_res);
            check("hold_res_rd", 32'(res_rd), 32'(rd));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("hs_res_valid", 32'(res_valid), 32'd0);
        check("hs_res_err", 32'(res_err), 32'd0);
        check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        if (!exp_err && rd != 3'd0) model_rf[rd] = exp_res;
    endtask

    initial begin
        logic [4:0] rop;
        int         sel;
        for (int i = 0; i < 8; i++) model_rf[i] = 32'h0;
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = 5'h0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_imm = '0;
        #12;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_err", 32'(res_err), 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_b", alu_b, 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        check("reset_res_data", res_data, 32'd0);
        check("reset_res_rd", 32'(res_rd), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load and add, back-to-back dependent.
        run_cmd(A_LDI, 3'd1, 3'd0, 3'd0, 32'd5, 0, 1'b0, got);
        run_cmd(A_LDI, 3'd2, 3'd0, 3'd0, 32'd7, 0, 1'b0, got);
        run_cmd(A_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 0, 1'b0, got);
        check("add_5_7", got, 32'd12);

        // Wrap-around and subtraction from r0.
        run_cmd(A_LDI, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 0, 1'b0, got);
        run_cmd(A_ADD, 3'd2, 3'd1, 3'd1, 32'd0, 0, 1'b0, got);
        check("add_wrap", got, 32'hFFFF_FFFE);
        run_cmd(A_SUB, 3'd3, 3'd0, 3'd1, 32'd0, 0, 1'b0, got);
        check("sub_r0", got, 32'h8000_0001);

        // Illegal opcode leaves rd untouched; readback under 5 cycles of backpressure.
        run_cmd(A_LDI, 3'd5, 3'd0, 3'd0, 32'hAA, 0, 1'b0, got);
        run_cmd(5'h07, 3'd5, 3'd1, 3'd2, 32'h1234, 0, 1'b0, got);
        check("illegal_data", got, 32'd0);
        run_cmd(A_ADD, 3'd6, 3'd5, 3'd0, 32'd0, 5, 1'b0, got);
        check("illegal_rd_kept", got, 32'hAA);

        // Writes to r0 are discarded but still returned.
        run_cmd(A_ADD, 3'd0, 3'd5, 3'd5, 32'd0, 0, 1'b0, got);
        check("r0_result", got, 32'h154);
        run_cmd(A_OR, 3'd7, 3'd0, 3'd0, 32'd0, 0, 1'b0, got);
        check("r0_reads_zero", got, 32'd0);

        // Logic operations.
        run_cmd(A_LDI, 3'd1, 3'd0, 3'd0, 32'hF0F0_F0F0, 0, 1'b0, got);
        run_cmd(A_LDI, 3'd2, 3'd0, 3'd0, 32'h0FF0_0FF0, 0, 1'b0, got);
        run_cmd(A_AND, 3'd3, 3'd1, 3'd2, 32'd0, 0, 1'b0, got);
        check("and", got, 32'h00F0_00F0);
        run_cmd(A_OR, 3'd3, 3'd1, 3'd2, 32'd0, 1, 1'b0, got);
        check("or", got, 32'hFFF0_FFF0);
        run_cmd(A_XOR, 3'd3, 3'd1, 3'd2, 32'd0, 0, 1'b0, got);
        check("xor", got, 32'hFF00_FF00);
        run_cmd(A_NOR, 3'd3, 3'd1, 3'd2, 32'd0, 0, 1'b0, got);
        check("nor", got, 32'h000F_000F);

        // Reset in the middle of a response clears everything.
        run_cmd(A_LDI, 3'd1, 3'd0, 3'd0, 32'd5, 0, 1'b1, got);
        run_cmd(A_ADD, 3'd4, 3'd1, 3'd0, 32'd0, 0, 1'b0, got);
        check("r1_after_reset", got, 32'd0);

        // Randomized commands against the model.
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 6)      rop = 5'(sel);
            else if (sel <= 8) rop = A_LDI;
            else               rop = 5'($urandom_range(7, 30));
            run_cmd(rop, 3'($urandom), 3'($urandom), 3'($urandom), $urandom,
                    int'($urandom_range(0, 3)), 1'b0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
